// File: rtl/pmc_readout_ctrl.sv
// Readout sequencer for the pixel-matrix column shift chain.
// Drives sh/pclk for the PMC receiver and flags completed words and transactions.
module pmc_readout_ctrl #(
    parameter int BITS_PER_WORD = 16,
    parameter int SETUP_CYCLES  = 2,
    parameter int FINISH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] word_count,
    input  logic [3:0] gap_cycles,
    output logic       sh,
    output logic       pclk,
    output logic       busy,
    output logic       word_done,
    output logic       done,
    output logic       aborted,
    output logic [7:0] words_left
);

    localparam int BIT_W   = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int PHASE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_WORD_END,
        S_FINISH
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [BIT_W-1:0]   bit_cnt;
    logic [3:0]         gap_cnt;
    logic [3:0]         gap_len;
    logic [PHASE_W-1:0] phase_cnt;
    logic               zero_done;

    logic active;
    logic setup_last;
    logic finish_last;
    logic bit_last;
    logic gap_last;

    assign active      = (state == S_SETUP) || (state == S_PULSE) ||
                         (state == S_GAP)   || (state == S_WORD_END);
    assign setup_last  = (phase_cnt == PHASE_W'(SETUP_CYCLES - 1));
    assign finish_last = (phase_cnt == PHASE_W'(FINISH_CYCLES - 1));
    assign bit_last    = (bit_cnt == BIT_W'(BITS_PER_WORD - 1));
    assign gap_last    = (gap_cnt == gap_len - 4'd1);

    // NOTE: every output of this always_comb gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        sh         = 1'b0;
        pclk       = 1'b0;
        busy       = (state != S_IDLE);
        word_done  = 1'b0;
        done       = zero_done;

        case (state)
            S_IDLE: begin
                if (start && (word_count != 8'd0)) state_next = S_SETUP;
            end
            S_SETUP: begin
                sh = 1'b1;
                if (abort)           state_next = S_FINISH;
                else if (setup_last) state_next = S_PULSE;
            end
            S_PULSE: begin
                sh   = 1'b1;
                pclk = 1'b1;
                if (abort)         state_next = S_FINISH;
                else if (bit_last) state_next = S_WORD_END;
                else               state_next = S_GAP;
            end
            S_GAP: begin
                sh = 1'b1;
                if (abort)         state_next = S_FINISH;
                else if (gap_last) state_next = S_PULSE;
            end
            S_WORD_END: begin
                // The word-end cycle doubles as the first inter-word gap cycle,
                // keeping pulse spacing uniform across word boundaries.
                sh        = 1'b1;
                word_done = 1'b1;
                if (abort || (words_left == 8'd1)) state_next = S_FINISH;
                else if (gap_len == 4'd1)          state_next = S_PULSE;
                else                               state_next = S_GAP;
            end
            S_FINISH: begin
                if (finish_last) begin
                    done       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            gap_len    <= '0;
            phase_cnt  <= '0;
            zero_done  <= 1'b0;
            aborted    <= 1'b0;
            words_left <= '0;
        end else begin
            state     <= state_next;
            zero_done <= (state == S_IDLE) && start && (word_count == 8'd0);

            if (state_next != state)
                phase_cnt <= '0;
            else if ((state == S_SETUP) || (state == S_FINISH))
                phase_cnt <= phase_cnt + 1'b1;

            if ((state == S_GAP) && (state_next == S_GAP))
                gap_cnt <= gap_cnt + 4'd1;
            else if (state == S_WORD_END)
                gap_cnt <= 4'd1;
            else
                gap_cnt <= '0;

            if (state == S_IDLE)
                bit_cnt <= '0;
            else if (state == S_PULSE)
                bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;

            if ((state == S_IDLE) && start) begin
                words_left <= word_count;
                gap_len    <= (gap_cycles == 4'd0) ? 4'd1 : gap_cycles;
                aborted    <= 1'b0;
            end else begin
                // A word completing in the abort cycle is still counted.
                if ((state == S_WORD_END) && (words_left != 8'd0))
                    words_left <= words_left - 8'd1;
                if (active && abort)
                    aborted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pmc_readout_ctrl.sv
// Self-checking bench for pmc_readout_ctrl: directed table, hand sequences and
// random transactions compared cycle by cycle against a timeline model.
module tb_pmc_readout_ctrl;

    localparam int S = 2;
    localparam int F = 2;
    localparam int B = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] word_count;
    logic [3:0] gap_cycles;
    logic       sh;
    logic       pclk;
    logic       busy;
    logic       word_done;
    logic       done;
    logic       aborted;
    logic [7:0] words_left;

    int n_checks = 0;
    int n_fail   = 0;

    pmc_readout_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .word_count(word_count),
        .gap_cycles(gap_cycles),
        .sh        (sh),
        .pclk      (pclk),
        .busy      (busy),
        .word_done (word_done),
        .done      (done),
        .aborted   (aborted),
        .words_left(words_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wc;
        int gap;
        int ab;
        int xs;
        int exp_pulses;
        int exp_wd;
        int exp_done;
        int exp_ab;
        int exp_wl;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] observed();
        return {sh, pclk, busy, word_done, done, aborted, words_left};
    endfunction

    // Last word-end cycle, relative to the start cycle (t=0).
    function automatic int last_word_end(input int wc, input int gap);
        int p;
        p = 1 + ((gap == 0) ? 1 : gap);
        return S + 2 + (wc - 1) * B * p + (B - 1) * p;
    endfunction

    function automatic int done_cycle(input int wc, input int gap, input int ab);
        int we;
        if (wc == 0) return 1;
        we = last_word_end(wc, gap);
        return ((ab >= 1 && ab <= we) ? ab : we) + F;
    endfunction

    // Expected outputs at cycle t>=1 of a transaction started at t=0.
    function automatic logic [13:0] model(input int t, input int wc, input int gap, input int ab);
        int  p, wlen, we, act_end, dc, off, r, nwd, c;
        bit  ab_eff, s_o, p_o, b_o, wd_o, d_o, a_o;
        if (wc == 0) return {4'b0000, (t == 1), 1'b0, 8'd0};
        p       = 1 + ((gap == 0) ? 1 : gap);
        wlen    = B * p;
        we      = last_word_end(wc, gap);
        ab_eff  = (ab >= 1) && (ab <= we);
        act_end = ab_eff ? ab : we;
        dc      = act_end + F;
        s_o     = (t >= 1) && (t <= act_end);
        b_o     = (t >= 1) && (t <= dc);
        d_o     = (t == dc);
        a_o     = ab_eff && (t > ab);
        p_o     = 1'b0;
        wd_o    = 1'b0;
        if (t >= S + 1 && t <= act_end) begin
            off  = t - S - 1;
            r    = off % wlen;
            p_o  = (r % p) == 0;
            wd_o = (r == (B - 1) * p + 1);
        end
        nwd = 0;
        for (int i = 0; i < wc; i++) begin
            c = S + 2 + i * wlen + (B - 1) * p;
            if (c < t && c <= act_end) nwd++;
        end
        return {s_o, p_o, b_o, wd_o, d_o, a_o, 8'(wc - nwd)};
    endfunction

    task automatic run_txn(input int wc, input int gap, input int ab, input int xs,
                           output int n_p, output int n_wd, output int d_c,
                           output int ab_f, output int wl_f);
        int dc;
        n_p  = 0;
        n_wd = 0;
        d_c  = -1;
        ab_f = -1;
        wl_f = -1;
        dc   = done_cycle(wc, gap, ab);
        @(negedge clk);
        start      = 1'b1;
        abort      = (ab == 0);
        word_count = 8'(wc);
        gap_cycles = 4'(gap);
        for (int t = 1; t <= dc + 2; t++) begin
            @(negedge clk);
            start = (t == xs);
            abort = (t == ab);
            check($sformatf("cycle wc=%0d gap=%0d ab=%0d t=%0d", wc, gap, ab, t),
                  32'(observed()), 32'(model(t, wc, gap, ab)));
            if (pclk) n_p++;
            if (word_done) n_wd++;
            if (done && d_c < 0) d_c = t;
            if (t == dc) ab_f = int'(aborted);
            if (t == dc + 1) wl_f = int'(words_left);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    vec_t tbl[11];
    int   n_p, n_wd, d_c, ab_f, wl_f;

    initial begin
        tbl[0]  = '{1,   1, -1, -1, 16,   1,   36,   0, 0};
        tbl[1]  = '{3,   3, -1, -1, 48,   3,   194,  0, 0};
        tbl[2]  = '{0,   5, -1, -1, 0,    0,   1,    0, 0};
        tbl[3]  = '{1,   0, -1, -1, 16,   1,   36,   0, 0};
        tbl[4]  = '{2,   1, 11, -1, 5,    0,   13,   1, 2};
        tbl[5]  = '{2,   2, 49, -1, 16,   1,   51,   1, 1};
        tbl[6]  = '{1,   1, 1,  -1, 0,    0,   3,    1, 1};
        tbl[7]  = '{1,   1, 35, -1, 16,   1,   36,   0, 0};
        tbl[8]  = '{1,   1, 0,  -1, 16,   1,   36,   0, 0};
        tbl[9]  = '{1,   1, -1, 10, 16,   1,   36,   0, 0};
        tbl[10] = '{255, 1, -1, -1, 4080, 255, 8164, 0, 0};

        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        word_count = '0;
        gap_cycles = '0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(observed()), 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_txn(tbl[i].wc, tbl[i].gap, tbl[i].ab, tbl[i].xs, n_p, n_wd, d_c, ab_f, wl_f);
            check($sformatf("vec%0d pulses", i),     32'(n_p),  32'(tbl[i].exp_pulses));
            check($sformatf("vec%0d word_done", i),  32'(n_wd), 32'(tbl[i].exp_wd));
            check($sformatf("vec%0d done_cycle", i), 32'(d_c),  32'(tbl[i].exp_done));
            check($sformatf("vec%0d aborted", i),    32'(ab_f), 32'(tbl[i].exp_ab));
            check($sformatf("vec%0d words_left", i), 32'(wl_f), 32'(tbl[i].exp_wl));
        end

        // Reset in the middle of a transaction, then a clean transaction.
        @(negedge clk);
        start      = 1'b1;
        word_count = 8'd3;
        gap_cycles = 4'd2;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_txn_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_txn_reset", 32'(observed()), 32'd0);
        rst = 1'b0;
        run_txn(1, 1, -1, -1, n_p, n_wd, d_c, ab_f, wl_f);
        check("post_reset done_cycle", 32'(d_c), 32'd36);
        check("post_reset pulses",     32'(n_p), 32'd16);

        for (int k = 0; k < 12; k++) begin
            int wc, gap, ab;
            wc  = int'($urandom_range(0, 4));
            gap = int'($urandom_range(0, 15));
            ab  = ($urandom_range(0, 2) == 0) ? -1
                : int'($urandom_range(1, wc * B * (1 + gap + 1) + 6));
            run_txn(wc, gap, ab, -1, n_p, n_wd, d_c, ab_f, wl_f);
            check($sformatf("rand%0d done_cycle", k), 32'(d_c), 32'(done_cycle(wc, gap, ab)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
